// File: rtl/spi_controller_if.sv
// Request/response and SPI pin bundle between a requester and spi_controller.
// The controller uses the master modport; the requester/peripheral side uses slave.
interface spi_controller_if;
    logic       start;
    logic       read_write;
    logic [6:0] addr;
    logic [7:0] data;
    logic       cipo;
    logic       ready;
    logic       done;
    logic [7:0] rdata;
    logic       sclk;
    logic       copi;
    logic       n_cs;

    modport master (
        input  start, read_write, addr, data, cipo,
        output ready, done, rdata, sclk, copi, n_cs
    );
    modport slave (
        output start, read_write, addr, data, cipo,
        input  ready, done, rdata, sclk, copi, n_cs
    );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 initiator for 16-bit {rw, addr, data} register frames, MSB first.
// Every output comes straight from a register.
module spi_controller #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    spi_controller_if.master  bus
);
    typedef enum logic [2:0] {IDLE, LOW, HIGH, TAIL, GAP} state_e;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] frame_q, frame_d;
    logic        rw_q, rw_d;
    logic [7:0]  cap_q, cap_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        sclk_q, sclk_d;
    logic        copi_q, copi_d;
    logic        ncs_q, ncs_d;
    logic        div_last;

    assign div_last = (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        rw_d    = rw_q;
        cap_d   = cap_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        sclk_d  = sclk_q;
        copi_d  = copi_q;
        ncs_d   = ncs_q;
        if (state_q != IDLE) div_d = div_last ? 8'd0 : div_q + 8'd1;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.start) begin
                    // frame_q holds the bits still to send, next one at [15]
                    frame_d = {bus.addr, bus.data, 1'b0};
                    rw_d    = bus.read_write;
                    copi_d  = bus.read_write;
                    cap_d   = 8'h00;
                    bit_d   = 4'd15;
                    div_d   = 8'd0;
                    ncs_d   = 1'b0;
                    ready_d = 1'b0;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (div_last) begin
                    sclk_d  = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (div_last) begin
                    if (bit_q <= 4'd7 && !rw_q) cap_d = {cap_q[6:0], bus.cipo};
                    sclk_d = 1'b0;
                    if (bit_q != 4'd0) begin
                        copi_d  = frame_q[15];
                        frame_d = {frame_q[14:0], 1'b0};
                        bit_d   = bit_q - 4'd1;
                        state_d = LOW;
                    end else begin
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                if (div_last) begin
                    ncs_d   = 1'b1;
                    copi_d  = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (div_last) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    if (!rw_q) rdata_d = cap_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= 8'd0;
            bit_q   <= 4'd0;
            frame_q <= 16'h0000;
            rw_q    <= 1'b0;
            cap_q   <= 8'h00;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            rdata_q <= 8'h00;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            ncs_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            rw_q    <= rw_d;
            cap_q   <= cap_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            ncs_q   <= ncs_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
    assign bus.sclk  = sclk_q;
    assign bus.copi  = copi_q;
    assign bus.n_cs  = ncs_q;
endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: CLK_DIV=4 and CLK_DIV=2 instances, frames observed on the
// pins and compared with frame-level expectations (bit order, timing, captured data).
module tb_spi_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic       start_t = 1'b0;
    logic       rw_t = 1'b0;
    logic [6:0] addr_t = '0;
    logic [7:0] data_t = '0;
    logic       cipo_t = 1'b0;

    spi_controller_if if4 ();
    spi_controller_if if2 ();

    assign if4.start = start_t & ~sel;
    assign if2.start = start_t & sel;
    assign if4.read_write = rw_t;
    assign if2.read_write = rw_t;
    assign if4.addr = addr_t;
    assign if2.addr = addr_t;
    assign if4.data = data_t;
    assign if2.data = data_t;
    assign if4.cipo = cipo_t;
    assign if2.cipo = cipo_t;

    spi_controller #(.CLK_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    spi_controller #(.CLK_DIV(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic       m_sclk, m_copi, m_ncs, m_done, m_ready;
    logic [7:0] m_rdata;
    assign m_sclk  = sel ? if2.sclk  : if4.sclk;
    assign m_copi  = sel ? if2.copi  : if4.copi;
    assign m_ncs   = sel ? if2.n_cs  : if4.n_cs;
    assign m_done  = sel ? if2.done  : if4.done;
    assign m_ready = sel ? if2.ready : if4.ready;
    assign m_rdata = sel ? if2.rdata : if4.rdata;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] exp_rd [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one frame and watch it on the pins until done (bounded).
    task automatic run_frame(input logic rw, input logic [6:0] a, input logic [7:0] d,
                             input logic [7:0] resp);
        int cd, rises, ncs_low, done_t, first_rise, last_rise, last_fall, bad, busy;
        logic prev;
        logic [15:0] word;
        cd = sel ? 2 : 4;
        rises = 0; ncs_low = 0; done_t = -1; first_rise = -1;
        last_rise = 0; last_fall = 0; bad = 0; busy = 0; prev = 1'b0; word = '0;
        @(negedge clk);
        rw_t = rw; addr_t = a; data_t = d; start_t = 1'b1;
        @(negedge clk);
        start_t = 1'b0;
        rw_t = 1'($urandom); addr_t = 7'($urandom); data_t = 8'($urandom);
        for (int t = 1; t <= 40 * cd + 20; t++) begin
            if (t > 1) @(negedge clk);
            if (t == 1) busy = (!m_ready && !m_ncs) ? 1 : 0;
            if (!m_ncs) ncs_low++;
            if (m_sclk && !prev) begin
                rises++;
                word = {word[14:0], m_copi};
                if (rises == 1) first_rise = t;
                else if (t - last_fall != cd) bad++;
                last_rise = t;
            end
            if (!m_sclk && prev) begin
                if (t - last_rise != cd) bad++;
                last_fall = t;
                if (rises >= 8 && rises <= 15) cipo_t = resp[15 - rises];
            end
            prev = m_sclk;
            if (m_done) begin
                done_t = t;
                break;
            end
        end
        if (!rw) exp_rd[sel] = resp;
        check("busy_after_accept", busy, 1);
        check("first_rise", first_rise, cd + 1);
        check("rise_count", rises, 16);
        check("half_period", bad, 0);
        check("ncs_low", ncs_low, 33 * cd);
        check("copi_word", word, {rw, a, d});
        check("done_time", done_t, 34 * cd + 1);
        check("rdata", m_rdata, exp_rd[sel]);
        check("ready_at_done", m_ready, 1);
        @(negedge clk);
        check("done_width", m_done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "watchdog");
    end

    initial begin
        int falls, dones, rise_t, fall2_t, rises;
        logic pn;
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ncs", if4.n_cs, 1);
        check("rst_sclk", if4.sclk, 0);
        check("rst_copi", if4.copi, 0);
        check("rst_ready", if4.ready, 1);
        check("rst_done", if4.done, 0);
        check("rst_rdata", if4.rdata, 8'h00);
        rst = 1'b0;

        // Directed CLK_DIV=4 frames
        run_frame(1'b1, 7'h2A, 8'hA5, 8'h00);
        run_frame(1'b0, 7'h05, 8'($urandom), 8'h3C);
        run_frame(1'b1, 7'($urandom), 8'($urandom), 8'($urandom));

        // Random frames
        for (int i = 0; i < 6; i++)
            run_frame(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));

        // Back-to-back with start held high
        @(negedge clk);
        rw_t = 1'b1; addr_t = 7'h11; data_t = 8'h22; start_t = 1'b1;
        falls = 0; dones = 0; rise_t = -1; fall2_t = -1; pn = 1'b1;
        for (int t = 1; t <= 274; t++) begin
            @(negedge clk);
            if (!if4.n_cs && pn) begin
                falls++;
                if (falls == 2) fall2_t = t;
            end
            if (if4.n_cs && !pn && rise_t < 0) rise_t = t;
            pn = if4.n_cs;
            if (if4.done) dones++;
            if (t == 274) start_t = 1'b0;
        end
        check("b2b_frames", falls, 2);
        check("b2b_dones", dones, 2);
        check("b2b_gap", fall2_t - rise_t, 5);
        check("b2b_rdata", if4.rdata, exp_rd[0]);

        // Reset mid-frame after 5 sclk rises
        @(negedge clk);
        rw_t = 1'b0; addr_t = 7'h33; data_t = 8'h44; start_t = 1'b1;
        @(negedge clk);
        start_t = 1'b0;
        rises = 0; pn = 1'b0;
        for (int t = 0; t < 200 && rises < 5; t++) begin
            @(negedge clk);
            if (if4.sclk && !pn) rises++;
            pn = if4.sclk;
        end
        check("mid_rises", rises, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
        check("mid_ncs", if4.n_cs, 1);
        check("mid_sclk", if4.sclk, 0);
        check("mid_ready", if4.ready, 1);
        dones = 0;
        for (int t = 0; t < 150; t++) begin
            @(negedge clk);
            if (if4.done) dones++;
        end
        check("mid_no_done", dones, 0);
        run_frame(1'b0, 7'($urandom), 8'($urandom), 8'($urandom));

        // CLK_DIV=2 instance
        sel = 1'b1;
        run_frame(1'b1, 7'h7F, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++)
            run_frame(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
